fill_r: RTL and testbench
=========================

FILL_R -- requirements
Module: fill_r

Interface
REQ-001 Parameters: ADDR_W 64, address width; DATA_W 512, cache-line data width (one beat); ID_W 16, AXI ID width; TID_W 10, transaction-tag width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rid_i  input  ID_W  AXI R ID from memory; not used for matching.
REQ-005 rdata_i  input  DATA_W  AXI R line data.
REQ-006 rresp_i  input  2  AXI R response; 2'b00 OKAY, any other value is an error.
REQ-007 rlast_i  input  1  AXI R last; each response is exactly one beat.
REQ-008 rvalid_i  input  1  AXI R valid.
REQ-009 rready_o  output  1  AXI R ready.
REQ-010 rmfifo_aempty_i  input  1  read-miss FIFO almost-empty; low = head entry valid (first-word-fall-through).
REQ-011 rmfifo_rden_o  output  1  read-miss FIFO pop strobe.
REQ-012 rmfifo_data_i  input  TID_W+ADDR_W  head entry, {tid, addr}.
REQ-013 rdfifo_afull_i  input  1  host read-data FIFO almost-full.
REQ-014 rdfifo_wren_o  output  1  host read-data FIFO push strobe.
REQ-015 rdfifo_data_o  output  TID_W+DATA_W  {tid, data} returned to host.
REQ-016 fillfifo_afull_i  input  1  cache fill FIFO almost-full.
REQ-017 fillfifo_wren_o  output  1  cache fill FIFO push strobe.
REQ-018 fillfifo_data_o  output  ADDR_W+DATA_W  {addr, data} line to install.
REQ-019 err_o  output  1  sticky error flag.

Function
REQ-020 Memory returns responses in issue order, so the read-miss FIFO head always pairs with the next R beat.
REQ-021 FSM states: S_IDLE, S_WAIT, S_PUSH.
REQ-022 S_IDLE: if rmfifo_aempty_i=0, assert rmfifo_rden_o for exactly one cycle, latch {tid, addr} from rmfifo_data_i, and go to S_WAIT; otherwise stay in S_IDLE.
REQ-023 rmfifo_rden_o is asserted only in the S_IDLE cycle that transitions to S_WAIT.
REQ-024 S_WAIT: rready_o = !rdfifo_afull_i && !fillfifo_afull_i, registered-free (combinational from state and inputs); rready_o is 0 in all other states.
REQ-025 S_WAIT: on rvalid_i && rready_o, latch rdata_i and rresp_i, then go to S_PUSH; otherwise hold state and latched data.
REQ-026 S_PUSH: assert rdfifo_wren_o for one cycle with rdfifo_data_o = {latched tid, latched data}.
REQ-027 S_PUSH, latched rresp = 00: also assert fillfifo_wren_o for one cycle with fillfifo_data_o = {latched addr, latched data}.
REQ-028 S_PUSH, latched rresp != 00: do not assert fillfifo_wren_o, and set err_o.
REQ-029 S_PUSH always transitions to S_IDLE; back-to-back throughput is one line per 3 cycles.
REQ-030 Latency, all FIFOs ready: pop in cycle N, R accepted at the earliest in N+1, pushes in N+2.
REQ-031 A beat accepted with rlast_i=0 sets err_o; it is otherwise processed normally.
REQ-032 rvalid_i in S_IDLE or S_PUSH is not accepted (rready_o=0); the beat is held by the AXI source.
REQ-033 Almost-full asserted mid-S_WAIT deasserts rready_o the same cycle; the transfer completes once both almost-full inputs clear.
REQ-034 Data outputs hold their last latched values when the corresponding write enable is low.
REQ-035 err_o, once set, remains 1 until reset.

Reset
REQ-036 On a clk edge with rst_n=0: state goes to S_IDLE; latched tid/addr/data/resp clear to 0; err_o=0.
REQ-037 During reset: rready_o, rmfifo_rden_o, rdfifo_wren_o and fillfifo_wren_o are all 0.
REQ-038 Reset asserted in S_WAIT or S_PUSH abandons the transaction: no FIFO push occurs, and the popped entry is lost.

Verification
REQ-039 Entry {tid=1, addr=1} present; R beat {data=0xAB..AB, resp=00, last=1} in the next cycle -> one pop, rdfifo_data_o={1, 0xAB..AB}, fillfifo_data_o={1, 0xAB..AB}, pushes two cycles after the pop, err_o=0.
REQ-040 rdfifo_afull_i=1 for 5 cycles in S_WAIT with rvalid_i=1 -> rready_o=0 for those cycles, no push, accept on the first cycle afull drops.
REQ-041 resp=2'b10 for tid=3 -> rdfifo push of {3, data}, no fillfifo push, err_o=1 and held.
REQ-042 Two entries (tid 4, 5) with back-to-back R beats -> pushes in order 4 then 5, exactly 3 cycles apart.
REQ-043 rvalid_i=1 while rmfifo_aempty_i=1 -> rready_o=0, no pops, no pushes.
REQ-044 rst_n=0 asserted in S_WAIT -> next cycle: S_IDLE, all strobes 0, err_o=0, no push.

Source files
------------

// File: rtl/fill_r.sv
// Read-miss fill engine: pairs each popped read-miss entry with the next in-order AXI R beat and returns the line to host and cache.
// Latency: pop in cycle N, R beat accepted no earlier than N+1, pushes in N+2. Throughput is one line per 3 cycles.
// Backpressure: rready_o drops in the same cycle that either downstream almost-full is high. The R beat is held by the source until both clear.
module fill_r #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int ID_W   = 16,
    parameter int TID_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_W-1:0]           rid_i,
    input  logic [DATA_W-1:0]         rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic                      rmfifo_aempty_i,
    output logic                      rmfifo_rden_o,
    input  logic [TID_W+ADDR_W-1:0]   rmfifo_data_i,
    input  logic                      rdfifo_afull_i,
    output logic                      rdfifo_wren_o,
    output logic [TID_W+DATA_W-1:0]   rdfifo_data_o,
    input  logic                      fillfifo_afull_i,
    output logic                      fillfifo_wren_o,
    output logic [ADDR_W+DATA_W-1:0]  fillfifo_data_o,
    output logic                      err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t              state_q;
    logic [TID_W-1:0]    tid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          resp_q;
    logic                last_q;
    logic                err_q;
    logic                accept;

    // Responses come back in issue order, so the R ID carries no information here.
    logic unused_rid;
    assign unused_rid = ^rid_i;

    // Strobes are gated by rst_n so nothing moves while reset is held, even mid-transaction.
    assign rmfifo_rden_o   = rst_n && (state_q == S_IDLE) && !rmfifo_aempty_i;
    assign rready_o        = rst_n && (state_q == S_WAIT) && !rdfifo_afull_i && !fillfifo_afull_i;
    assign accept          = rready_o && rvalid_i;
    assign rdfifo_wren_o   = rst_n && (state_q == S_PUSH);
    assign fillfifo_wren_o = rst_n && (state_q == S_PUSH) && (resp_q == 2'b00);

    assign rdfifo_data_o   = {tid_q, data_q};
    assign fillfifo_data_o = {addr_q, data_q};
    assign err_o           = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tid_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= 2'b00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rmfifo_aempty_i) begin
                        tid_q   <= rmfifo_data_i[TID_W+ADDR_W-1:ADDR_W];
                        addr_q  <= rmfifo_data_i[ADDR_W-1:0];
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        data_q  <= rdata_i;
                        resp_q  <= rresp_i;
                        last_q  <= rlast_i;
                        state_q <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    // An error response or a missing rlast poisons the sticky flag; the host still gets the beat.
                    if ((resp_q != 2'b00) || !last_q) begin
                        err_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_r.sv
// Bench for fill_r: directed scenarios plus randomized traffic scored against a transaction-level model.
module tb_fill_r;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 16;
    localparam int TID_W  = 10;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [ID_W-1:0]          rid_i;
    logic [DATA_W-1:0]        rdata_i;
    logic [1:0]               rresp_i;
    logic                     rlast_i;
    logic                     rvalid_i;
    logic                     rready_o;
    logic                     rmfifo_aempty_i;
    logic                     rmfifo_rden_o;
    logic [TID_W+ADDR_W-1:0]  rmfifo_data_i;
    logic                     rdfifo_afull_i;
    logic                     rdfifo_wren_o;
    logic [TID_W+DATA_W-1:0]  rdfifo_data_o;
    logic                     fillfifo_afull_i;
    logic                     fillfifo_wren_o;
    logic [ADDR_W+DATA_W-1:0] fillfifo_data_o;
    logic                     err_o;

    fill_r #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TID_W(TID_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rid_i            (rid_i),
        .rdata_i          (rdata_i),
        .rresp_i          (rresp_i),
        .rlast_i          (rlast_i),
        .rvalid_i         (rvalid_i),
        .rready_o         (rready_o),
        .rmfifo_aempty_i  (rmfifo_aempty_i),
        .rmfifo_rden_o    (rmfifo_rden_o),
        .rmfifo_data_i    (rmfifo_data_i),
        .rdfifo_afull_i   (rdfifo_afull_i),
        .rdfifo_wren_o    (rdfifo_wren_o),
        .rdfifo_data_o    (rdfifo_data_o),
        .fillfifo_afull_i (fillfifo_afull_i),
        .fillfifo_wren_o  (fillfifo_wren_o),
        .fillfifo_data_o  (fillfifo_data_o),
        .err_o            (err_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [TID_W-1:0]  tid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } txn_t;

    // Model: entries waiting in the read-miss FIFO, the one transaction in flight, and the sticky error.
    txn_t rmq[$];
    txn_t cur;
    bit   inflight, accepted, rv_hold, err_e;
    int   cyc, acc_cyc, pop_cyc;
    int   push_cyc[$];
    int   total, bad;

    // Stimulus knobs.
    bit force_empty, rd_af, fill_af, rv_allow, rv_spurious, rst_drv;

    task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic txn_t mk(input int tid, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input logic [1:0] resp, input logic last);
        txn_t t;
        t.tid  = tid[TID_W-1:0];
        t.addr = addr;
        t.data = data;
        t.resp = resp;
        t.last = last;
        return t;
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, then advance the model.
    task automatic step();
        bit owe, pop_e, rdy_e, push_e;
        @(negedge clk);
        rst_n           = rst_drv;
        rid_i           = ID_W'($urandom);
        rmfifo_aempty_i = force_empty || (rmq.size() == 0);
        rmfifo_data_i   = (rmq.size() != 0) ? {rmq[0].tid, rmq[0].addr} : '0;
        owe             = inflight && !accepted;
        rvalid_i        = (owe && (rv_hold || rv_allow)) || (!owe && rv_spurious);
        if (owe) begin
            rdata_i = cur.data;
            rresp_i = cur.resp;
            rlast_i = cur.last;
        end else begin
            rdata_i = rnd_line();
            rresp_i = 2'($urandom);
            rlast_i = 1'($urandom);
        end
        rdfifo_afull_i   = rd_af;
        fillfifo_afull_i = fill_af;
        #1;
        cyc++;
        pop_e  = rst_drv && !inflight && !rmfifo_aempty_i;
        rdy_e  = rst_drv && inflight && !accepted && !rd_af && !fill_af;
        push_e = rst_drv && inflight && accepted;
        chk("rden",     rmfifo_rden_o,   pop_e);
        chk("rready",   rready_o,        rdy_e);
        chk("rd_wren",  rdfifo_wren_o,   push_e);
        chk("fill_wren", fillfifo_wren_o, push_e && (cur.resp == 2'b00));
        chk("err",      err_o,           err_e);
        if (push_e) begin
            chk("rd_data", rdfifo_data_o, {cur.tid, cur.data});
            if (cur.resp == 2'b00) chk("fill_data", fillfifo_data_o, {cur.addr, cur.data});
            chk("push_after_accept", cyc - acc_cyc, 1);
            push_cyc.push_back(cyc);
            if ((cur.resp != 2'b00) || !cur.last) err_e = 1'b1;
            inflight = 1'b0;
            accepted = 1'b0;
        end
        if (rdy_e && rvalid_i) begin
            accepted = 1'b1;
            acc_cyc  = cyc;
            rv_hold  = 1'b0;
        end else if (owe && rvalid_i) begin
            rv_hold = 1'b1;
        end
        if (pop_e) begin
            cur      = rmq.pop_front();
            inflight = 1'b1;
            pop_cyc  = cyc;
        end
        if (!rst_drv) begin
            inflight = 1'b0;
            accepted = 1'b0;
            rv_hold  = 1'b0;
            err_e    = 1'b0;
        end
    endtask

    task automatic quiet();
        force_empty = 0; rd_af = 0; fill_af = 0; rv_allow = 1; rv_spurious = 0; rst_drv = 1;
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((inflight || rmq.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout", inflight || (rmq.size() != 0), 0);
    endtask

    initial begin
        logic [DATA_W-1:0] ab_line;
        total = 0; bad = 0; cyc = 0; acc_cyc = 0; pop_cyc = 0;
        inflight = 0; accepted = 0; rv_hold = 0; err_e = 0;
        quiet();

        // Reset: strobes low during reset, cleared data after.
        rst_drv = 0;
        rmq.push_back(mk(9, 64'h9, rnd_line(), 2'b00, 1'b1));
        repeat (3) step();
        chk("rst_rd_data",   rdfifo_data_o,   0);
        chk("rst_fill_data", fillfifo_data_o, 0);
        rmq.delete();
        rst_drv = 1;
        step();

        // Single line, beat offered immediately.
        for (int i = 0; i < DATA_W / 8; i++) ab_line[i*8 +: 8] = 8'hAB;
        rmq.push_back(mk(1, 64'h1, ab_line, 2'b00, 1'b1));
        run_idle(20);
        chk("lat_pop_to_push", push_cyc[push_cyc.size()-1] - pop_cyc, 2);
        chk("ab_rd_data",   rdfifo_data_o,   {10'd1, ab_line});
        chk("ab_fill_data", fillfifo_data_o, {64'd1, ab_line});
        step();

        // Host FIFO almost-full for 5 cycles while the beat is waiting.
        rmq.push_back(mk(2, 64'h2222, rnd_line(), 2'b00, 1'b1));
        rd_af = 1;
        step();
        repeat (5) step();
        chk("af_no_accept", accepted, 0);
        rd_af = 0;
        step();
        chk("af_accept_now", acc_cyc, cyc);
        run_idle(10);

        // Error response still returns data to the host but skips the fill.
        rmq.push_back(mk(3, 64'h3333, rnd_line(), 2'b10, 1'b1));
        run_idle(10);
        repeat (4) step();
        chk("err_held", err_o, 1);

        // Back-to-back lines are three cycles apart.
        push_cyc.delete();
        rmq.push_back(mk(4, 64'h4444, rnd_line(), 2'b00, 1'b1));
        rmq.push_back(mk(5, 64'h5555, rnd_line(), 2'b00, 1'b1));
        run_idle(20);
        chk("b2b_count", push_cyc.size(), 2);
        if (push_cyc.size() == 2) chk("b2b_gap", push_cyc[1] - push_cyc[0], 3);

        // Stray rvalid with nothing outstanding.
        rv_spurious = 1;
        repeat (5) step();
        rv_spurious = 0;

        // Reset in S_WAIT drops the transaction.
        rmq.push_back(mk(6, 64'h6666, rnd_line(), 2'b00, 1'b1));
        fill_af = 1;
        repeat (2) step();
        rst_drv = 0;
        step();
        rst_drv = 1;
        fill_af = 0;
        push_cyc.delete();
        repeat (4) step();
        chk("rst_wait_no_push", push_cyc.size(), 0);
        chk("rst_wait_err", err_o, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (rmq.size() < 4 && $urandom_range(0, 2) == 0)
                rmq.push_back(mk($urandom_range(0, 1023), {$urandom, $urandom}, rnd_line(),
                                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                                 $urandom_range(0, 15) != 0));
            force_empty = ($urandom_range(0, 4) == 0);
            rd_af       = ($urandom_range(0, 4) == 0);
            fill_af     = ($urandom_range(0, 6) == 0);
            rv_allow    = ($urandom_range(0, 9) < 6);
            rv_spurious = ($urandom_range(0, 3) == 0);
            rst_drv     = ($urandom_range(0, 299) != 0);
            step();
        end
        quiet();
        run_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
